// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite bus arbiter: registered one-hot grant plus address/data
// phase owner pipeline, all stages advancing only on HREADY-qualified edges.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] M_HBUSREQ,
  input  logic [NUM_MASTERS-1:0] M_HLOCK,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] M_HGRANT,
  output logic [1:0]             HMASTER,
  output logic [1:0]             HMASTER_D,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] DEFAULT_IDX = 2'(DEFAULT_MASTER);
  localparam logic [2:0] NUM_M3      = 3'(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  // Round-robin pointer: always the index of the set bit of grant_reg.
  logic [1:0]             owner_reg, owner_next;
  logic [1:0]             hmaster_reg, hmaster_d_reg;
  logic                   hmastlock_reg;
  logic [3:0]             req_ext, lock_ext;
  logic [1:0]             cand_idx [NUM_MASTERS-1];
  logic [NUM_MASTERS-2:0] cand_req;

  assign req_ext  = 4'(M_HBUSREQ);
  assign lock_ext = 4'(M_HLOCK);

  // Candidate gi is the master (owner + gi + 1) mod NUM_MASTERS.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS - 1; gi++) begin : g_cand
      logic [2:0] sum_w;
      assign sum_w        = {1'b0, owner_reg} + 3'(gi + 1);
      assign cand_idx[gi] = (sum_w >= NUM_M3) ? 2'(sum_w - NUM_M3) : sum_w[1:0];
      assign cand_req[gi] = req_ext[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    owner_next = DEFAULT_IDX;
    if (lock_ext[owner_reg] || req_ext[owner_reg]) begin
      owner_next = owner_reg;
    end else begin
      // Walk from the farthest candidate back so the nearest requester wins.
      for (int i = NUM_MASTERS - 2; i >= 0; i--) begin
        if (cand_req[i]) owner_next = cand_idx[i];
      end
    end
    grant_next = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      grant_next[i] = (owner_next == 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg     <= DEFAULT_GRANT;
      owner_reg     <= DEFAULT_IDX;
      hmaster_reg   <= DEFAULT_IDX;
      hmaster_d_reg <= DEFAULT_IDX;
      hmastlock_reg <= 1'b0;
    end else if (HREADY) begin
      grant_reg     <= grant_next;
      owner_reg     <= owner_next;
      hmaster_reg   <= owner_reg;
      hmastlock_reg <= lock_ext[owner_reg];
      hmaster_d_reg <= hmaster_reg;
    end
  end

  assign M_HGRANT  = grant_reg;
  assign HMASTER   = hmaster_reg;
  assign HMASTER_D = hmaster_d_reg;
  assign HMASTLOCK = hmastlock_reg;

endmodule
